booth_mac_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiply-accumulate unit, successor to the fixed 8-bit Booth multiplier.
- Multiplies two WIDTH-bit operands, signed or unsigned per operation, selected by a mode input.
- Adds the exact 2*WIDTH product into an ACC_WIDTH accumulator. Overflow is flagged.
- Uses a start/busy/done handshake. Sits in the datapath of the MAC/filter engine.

---
 rtl/booth_mac_seq.sv | 145 ++++++++++++++
 tb/tb_booth_mac_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_seq.sv
// Sequential radix-2 Booth multiply-accumulate with start/busy/done handshake.
// Define MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module booth_mac_seq #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       w,
  input  logic [WIDTH-1:0]       x,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   ovf
);

  localparam int CW = $clog2(WIDTH+2);

  typedef enum logic [1:0] {
    IDLE, CALC, ACCUM, DONE
  } state_t;

  state_t state, state_n;

  // A carries one guard bit above the extended operand width
  logic [WIDTH+1:0]   a;
  logic [WIDTH:0]     q;
  logic               q1;
  logic [WIDTH:0]     wx;
  logic               sm;
  logic [CW-1:0]      cnt;

  logic [WIDTH+1:0]     addend;
  logic [WIDTH+1:0]     sum;
  logic [2*WIDTH-1:0]   prod_n;
  logic [ACC_WIDTH-1:0] pe;
  logic [ACC_WIDTH:0]   asum;
  logic                 ov;
  logic [ACC_WIDTH-1:0] acc_n;

  assign addend = {wx[WIDTH], wx};

  always_comb begin
    sum = a;
    unique case ({q[0], q1})
      2'b01:   sum = a + addend;
      2'b10:   sum = a - addend;
      default: sum = a;
    endcase
  end

  assign prod_n = {a[WIDTH-2:0], q};
  assign pe     = sm ? ACC_WIDTH'($signed(prod_n))
                     : ACC_WIDTH'(prod_n);
  assign asum   = {1'b0, acc} + {1'b0, pe};

  always_comb begin
    ov    = 1'b0;
    acc_n = asum[ACC_WIDTH-1:0];
    if (sm)
      ov = (acc[ACC_WIDTH-1] == pe[ACC_WIDTH-1]) &&
           (asum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    else
      ov = asum[ACC_WIDTH];
`ifdef MAC_SAT_EN
    if (ov) begin
      if (!sm)
        acc_n = '1;
      else if (acc[ACC_WIDTH-1])
        acc_n = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else
        acc_n = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (cnt == '0) state_n = ACCUM;
      ACCUM:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      q1      <= 1'b0;
      wx      <= '0;
      sm      <= 1'b0;
      cnt     <= '0;
      product <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
          end
          if (start) begin
            sm  <= signed_mode;
            wx  <= signed_mode ? {w[WIDTH-1], w} : {1'b0, w};
            q   <= signed_mode ? {x[WIDTH-1], x} : {1'b0, x};
            a   <= '0;
            q1  <= 1'b0;
            cnt <= CW'(WIDTH+1);
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a   <= {sum[WIDTH+1], sum[WIDTH+1:1]};
            q   <= {sum[0], q[WIDTH:1]};
            q1  <= q[0];
            cnt <= cnt - CW'(1);
          end
        end
        ACCUM: begin
          product <= prod_n;
          acc     <= acc_n;
          if (ov) ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed bench for booth_mac_seq: default 24-bit and narrow 16-bit
// accumulator instances share stimulus.
module tb_booth_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  w = '0;
  logic [7:0]  x = '0;

  logic        busy0, done0, ovf0;
  logic [15:0] prod0;
  logic [23:0] acc0;
  logic        busy1, done1, ovf1;
  logic [15:0] prod1;
  logic [15:0] acc1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mac_seq #(.WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(signed_mode), .clr(clr), .w(w), .x(x),
    .busy(busy0), .done(done0), .product(prod0),
    .acc(acc0), .ovf(ovf0)
  );

  booth_mac_seq #(.WIDTH(8), .ACC_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .signed_mode(signed_mode), .clr(clr), .w(w), .x(x),
    .busy(busy1), .done(done1), .product(prod1),
    .acc(acc1), .ovf(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

`ifdef MAC_SAT_EN
  localparam logic [15:0] SAT_SP = 16'h7FFF;
  localparam logic [15:0] SAT_SN = 16'h8000;
  localparam logic [15:0] SAT_U  = 16'hFFFF;
`else
  localparam logic [15:0] SAT_SP = 16'hBD03;
  localparam logic [15:0] SAT_SN = 16'h4180;
  localparam logic [15:0] SAT_U  = 16'hFC02;
`endif

  typedef struct {
    logic        c;
    logic        sm;
    logic [7:0]  w;
    logic [7:0]  x;
    logic [15:0] p;
    logic [23:0] a24;
    logic [15:0] a16;
    logic        o16;
  } vec_t;

  vec_t vt[13];

  // Issue one operation; inject=1 pulses start/clr with other
  // operands mid-operation. Returns edges from start to done.
  task automatic do_op(input logic c, input logic sm,
                       input logic [7:0] wi, input logic [7:0] xi,
                       input logic inject, output int lat);
    lat = 0;
    @(negedge clk);
    clr = c; signed_mode = sm; w = wi; x = xi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    signed_mode = ~sm; w = ~wi; x = ~xi;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("busy_after_start", busy0, 1'b1);
      if (inject && k == 3) begin
        start = 1'b1; clr = 1'b1; w = 8'h05; x = 8'h05;
      end
      if (inject && k == 4) begin
        start = 1'b0; clr = 1'b0;
      end
      if (done0) begin
        lat = k;
        break;
      end
    end
    start = 1'b0; clr = 1'b0;
    if (lat != 0) begin
      @(posedge clk);
      #1;
      chk("done_pulse", {busy0, done0}, 2'b00);
    end
  endtask

  int lat;

  initial begin
    vt[0]  = '{1, 1, 8'h80, 8'h80, 16'h4000, 24'h004000, 16'h4000, 0};
    vt[1]  = '{1, 0, 8'hFF, 8'hFF, 16'hFE01, 24'h00FE01, 16'hFE01, 0};
    vt[2]  = '{1, 0, 8'h80, 8'h02, 16'h0100, 24'h000100, 16'h0100, 0};
    vt[3]  = '{1, 1, 8'h03, 8'hFB, 16'hFFF1, 24'hFFFFF1, 16'hFFF1, 0};
    vt[4]  = '{0, 1, 8'h0A, 8'h02, 16'h0014, 24'h000005, 16'h0005, 0};
    vt[5]  = '{1, 1, 8'h7F, 8'h7F, 16'h3F01, 24'h003F01, 16'h3F01, 0};
    vt[6]  = '{0, 1, 8'h7F, 8'h7F, 16'h3F01, 24'h007E02, 16'h7E02, 0};
    vt[7]  = '{0, 1, 8'h7F, 8'h7F, 16'h3F01, 24'h00BD03, SAT_SP, 1};
    vt[8]  = '{1, 1, 8'h80, 8'h7F, 16'hC080, 24'hFFC080, 16'hC080, 0};
    vt[9]  = '{0, 1, 8'h80, 8'h7F, 16'hC080, 24'hFF8100, 16'h8100, 0};
    vt[10] = '{0, 1, 8'h80, 8'h7F, 16'hC080, 24'hFF4180, SAT_SN, 1};
    vt[11] = '{1, 0, 8'hFF, 8'hFF, 16'hFE01, 24'h00FE01, 16'hFE01, 0};
    vt[12] = '{0, 0, 8'hFF, 8'hFF, 16'hFE01, 24'h01FC02, SAT_U, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy0, done0, ovf0, prod0, acc0}, '0);
    chk("reset_acc16", {busy1, done1, ovf1, acc1}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vt[i].c, vt[i].sm, vt[i].w, vt[i].x, 1'b0, lat);
      chk($sformatf("latency[%0d]", i), lat, 11);
      chk($sformatf("product[%0d]", i), prod0, vt[i].p);
      chk($sformatf("acc24[%0d]", i), acc0, vt[i].a24);
      chk($sformatf("ovf24[%0d]", i), ovf0, 1'b0);
      chk($sformatf("acc16[%0d]", i), acc1, vt[i].a16);
      chk($sformatf("ovf16[%0d]", i), ovf1, vt[i].o16);
    end

    // Standalone clear in IDLE drops acc and the sticky flag
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_acc16", acc1, 16'h0);
    chk("clr_ovf16", ovf1, 1'b0);
    chk("clr_acc24", acc0, 24'h0);
    chk("clr_keeps_product", prod0, 16'hFE01);

    // Start and clr while busy are ignored
    do_op(1'b1, 1'b1, 8'h02, 8'h03, 1'b0, lat);
    chk("hs_first_acc", acc0, 24'h000006);
    do_op(1'b0, 1'b1, 8'h04, 8'h05, 1'b1, lat);
    chk("hs_lat", lat, 11);
    chk("hs_product", prod0, 16'h0014);
    chk("hs_acc", acc0, 24'h00001A);
    @(posedge clk);
    #1;
    chk("hs_not_queued", busy0, 1'b0);
    do_op(1'b1, 1'b1, 8'h03, 8'h03, 1'b0, lat);
    chk("clr_start_acc", acc0, 24'h000009);
    chk("clr_start_acc16", acc1, 16'h0009);

    // Reset four cycles into CALC
    @(negedge clk);
    signed_mode = 1'b1; w = 8'h7F; x = 8'h7F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {busy0, done0, ovf0, prod0, acc0}, '0);
    chk("rst_mid_acc16", {busy1, done1, ovf1, acc1}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 1'b1, 8'h02, 8'h03, 1'b0, lat);
    chk("post_rst_lat", lat, 11);
    chk("post_rst_product", prod0, 16'h0006);
    chk("post_rst_acc", acc0, 24'h000006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
